lif_stream_driver: RTL and testbench

LIF_STREAM_DRIVER -- requirements
Module: lif_stream_driver

---
 rtl/lif_pkg.sv | 23 ++
 rtl/lif_word_serializer.sv | 48 ++++
 rtl/lif_stream_driver.sv | 164 ++++++++++++++++
 tb/tb_lif_stream_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: types and constants shared by the LIF neuron stream driver.
//   lif_state_e    : driver FSM states
//   bytes_per_word : bytes per neuron word for a given N_STAGES (fan-in 2**N_STAGES)
//   BYTES_PER_WORD : bytes per word for the default fan-in of 32
//   NO_SPIKE       : rsp_first value meaning "no spike seen"
package lif_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_X = 3'd2,
    RUN    = 3'd3,
    RESP   = 3'd4
  } lif_state_e;

  function automatic int bytes_per_word(input int n_stages);
    return (2 ** n_stages) / 8;
  endfunction

  localparam int         BYTES_PER_WORD = bytes_per_word(5);
  localparam logic [7:0] NO_SPIKE       = 8'hFF;

endpackage

// File: rtl/lif_word_serializer.sv
// lif_word_serializer: word -> byte stream, MSB byte first.
//   start  : load word; its top byte appears on byte_o the next cycle
//   word   : word to send
//   byte_o : current byte (registered)
//   done   : high while the last byte of the word is on byte_o
// Without start the register rotates left by one byte every cycle, so after
// the last byte the first byte comes round again.
module lif_word_serializer
  import lif_pkg::*;
#(
  parameter int NB = BYTES_PER_WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NB*8-1:0] word,
  output logic [7:0]      byte_o,
  output logic            done
);

  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [NB*8-1:0] sh_q, sh_d;
  logic [CW-1:0]   idx_q, idx_d;

  always_comb begin
    sh_d  = (sh_q << 8) | (sh_q >> (NB*8 - 8));
    idx_d = (idx_q == CW'(NB-1)) ? '0 : idx_q + 1'b1;
    if (start) begin
      sh_d  = word;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

  assign byte_o = sh_q[NB*8-1 -: 8];
  assign done   = (idx_q == CW'(NB-1));

endmodule

// File: rtl/lif_stream_driver.sv
// lif_stream_driver: loads a byte-serial LIF neuron with a weight word and an
// input-spike word, runs it for cmd_steps integration cycles, and reports the
// spike count and first-spike step.
//   cmd_*   : command (valid/ready) with weights, inputs, steps
//   nrn_*   : registered neuron drive (data byte, weight/input select, run)
//             plus the neuron's spike output
//   rsp_*   : response (valid/ready) with spike count and first-spike step
// Optional: LIF_DRV_WEIGHT_CACHE_EN keeps the last loaded weight word and
// skips LOAD_W when a command brings the same weights again.
module lif_stream_driver
  import lif_pkg::*;
#(
  parameter int N_STAGES = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2**N_STAGES-1:0] cmd_weights,
  input  logic [2**N_STAGES-1:0] cmd_inputs,
  input  logic [7:0]             cmd_steps,
  output logic [7:0]             nrn_data,
  output logic                   nrn_sel_w,
  output logic                   nrn_run,
  input  logic                   nrn_spike,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_count,
  output logic [7:0]             rsp_first
);

  localparam int W  = 2 ** N_STAGES;
  localparam int NB = bytes_per_word(N_STAGES);

  lif_state_e     state_q;
  logic [W-1:0]   x_q;
  logic [7:0]     steps_q, step_q, cnt_q, first_q;
  logic           cmd_ready_q, rsp_valid_q, sel_w_q, run_q;

  logic           accept, hit, last_step;
  logic           ser_start, ser_done;
  logic [W-1:0]   ser_word;

  assign accept    = cmd_valid & cmd_ready_q;
  assign last_step = (step_q == steps_q - 8'd1);

`ifdef LIF_DRV_WEIGHT_CACHE_EN
  logic [W-1:0] wc_q;
  logic         wc_vld_q;

  assign hit = wc_vld_q && (cmd_weights == wc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_q     <= '0;
      wc_vld_q <= 1'b0;
    end else if (accept) begin
      wc_q     <= cmd_weights;
      wc_vld_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // The weight word is captured by the serializer on accept, so only the
  // input word needs its own copy (it is replayed in LOAD_X, RESP and IDLE).
  // Restarting on the input word when leaving LOAD_X or RUN keeps the
  // RESP/IDLE rotation in phase with the neuron's input register.
  always_comb begin
    ser_start = 1'b0;
    ser_word  = x_q;
    case (state_q)
      IDLE: if (accept) begin
        ser_start = 1'b1;
        ser_word  = hit ? cmd_inputs : cmd_weights;
      end
      LOAD_W, LOAD_X: ser_start = ser_done;
      RUN:            ser_start = last_step;
      default: ;
    endcase
  end

  lif_word_serializer #(.NB(NB)) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (ser_start),
    .word   (ser_word),
    .byte_o (nrn_data),
    .done   (ser_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cnt_q       <= 8'd0;
      first_q     <= NO_SPIKE;
      sel_w_q     <= 1'b0;
      run_q       <= 1'b0;
      x_q         <= '0;
      steps_q     <= 8'd0;
      step_q      <= 8'd0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          x_q         <= cmd_inputs;
          steps_q     <= cmd_steps;
          cnt_q       <= 8'd0;
          first_q     <= NO_SPIKE;
          cmd_ready_q <= 1'b0;
          if (hit) begin
            state_q <= LOAD_X;
          end else begin
            state_q <= LOAD_W;
            sel_w_q <= 1'b1;
          end
        end
        LOAD_W: if (ser_done) begin
          state_q <= LOAD_X;
          sel_w_q <= 1'b0;
        end
        LOAD_X: if (ser_done) begin
          step_q <= 8'd0;
          if (steps_q == 8'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end
        end
        RUN: begin
          // step index never reaches 255, so NO_SPIKE is unambiguous
          if (nrn_spike) begin
            if (cnt_q != 8'hFF)      cnt_q   <= cnt_q + 8'd1;
            if (first_q == NO_SPIKE) first_q <= step_q;
          end
          step_q <= step_q + 8'd1;
          if (last_step) begin
            state_q     <= RESP;
            run_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_count = cnt_q;
  assign rsp_first = first_q;
  assign nrn_sel_w = sel_w_q;
  assign nrn_run   = run_q;

endmodule

// File: tb/tb_lif_stream_driver.sv
// Bench for lif_stream_driver: a toy LIF neuron drives nrn_spike, a
// timeline model predicts every output each cycle, and directed commands
// pin the model to hand-computed traces. Honours LIF_DRV_WEIGHT_CACHE_EN.
module tb_lif_stream_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_weights = '0, cmd_inputs = '0;
  logic [7:0]  cmd_steps = '0;
  logic [7:0]  nrn_data;
  logic        nrn_sel_w, nrn_run, nrn_spike;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [7:0]  rsp_count, rsp_first;

  always #5 clk = ~clk;

  lif_stream_driver #(.N_STAGES(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_weights(cmd_weights), .cmd_inputs(cmd_inputs), .cmd_steps(cmd_steps),
    .nrn_data(nrn_data), .nrn_sel_w(nrn_sel_w), .nrn_run(nrn_run), .nrn_spike(nrn_spike),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_count(rsp_count), .rsp_first(rsp_first)
  );

  // ---- toy neuron: bytes shift in at the low end; integrates popcount(w&x)
  localparam int TH = 5;
  logic [31:0] nw = '0, nx = '0;
  int          mem = 0;
  assign nrn_spike = nrn_run && ((mem + $countones(nw & nx)) >= TH);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nw <= '0; nx <= '0; mem <= 0;
    end else if (!nrn_run) begin
      if (nrn_sel_w) nw <= {nw[23:0], nrn_data};
      else           nx <= {nx[23:0], nrn_data};
    end else begin
      mem <= nrn_spike ? 0 : mem + $countones(nw & nx);
    end
  end

  // ---- timeline model: m_k counts cycles since accept
  bit          m_busy = 0, m_resp = 0, mc_v = 0;
  int          m_k = 0, m_wlen = 4, m_steps = 0, m_cnt = 0, m_first = 255, m_rot = 0;
  logic [31:0] m_w = '0, m_x = '0, mc_w = '0;

  function automatic bit cache_hit(input logic [31:0] w);
`ifdef LIF_DRV_WEIGHT_CACHE_EN
    return mc_v && (w == mc_w);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int j);
    return w[8*(3-j) +: 8];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_resp <= 0; m_k <= 0; m_cnt <= 0; m_first <= 255;
      m_rot <= 0; m_w <= '0; m_x <= '0; mc_v <= 0;
    end else if (!m_busy) begin
      m_rot <= m_rot + 1;
      if (cmd_valid) begin
        m_busy <= 1; m_k <= 0; m_w <= cmd_weights; m_x <= cmd_inputs;
        m_steps <= int'(cmd_steps); m_cnt <= 0; m_first <= 255;
        m_wlen <= cache_hit(cmd_weights) ? 0 : 4;
        mc_w <= cmd_weights; mc_v <= 1;
      end
    end else if (!m_resp) begin
      if (m_k >= m_wlen + 4 && nrn_spike) begin
        if (m_cnt < 255)    m_cnt   <= m_cnt + 1;
        if (m_first == 255) m_first <= m_k - m_wlen - 4;
      end
      m_k <= m_k + 1;
      if (m_k + 1 == m_wlen + 4 + m_steps) begin m_resp <= 1; m_rot <= 0; end
    end else begin
      m_rot <= m_rot + 1;
      if (rsp_ready) begin m_busy <= 0; m_resp <= 0; end
    end
  end

  // ---- checking
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("rsp_valid", rsp_valid, m_resp);
    chk("rsp_count", rsp_count, m_cnt);
    chk("rsp_first", rsp_first, m_first);
    chk("nrn_run",   nrn_run,   m_busy && !m_resp && (m_k >= m_wlen + 4));
    chk("nrn_sel_w", nrn_sel_w, m_busy && !m_resp && (m_k < m_wlen));
    if (m_busy && !m_resp && m_k < m_wlen + 4)
      chk("nrn_data_load", nrn_data, byte_of((m_k < m_wlen) ? m_w : m_x, m_k % 4));
    else if (!m_busy || m_resp)
      chk("nrn_data_rot", nrn_data, byte_of(m_x, m_rot % 4));
  end

  // ---- per-command trace (cycles from accept up to rsp_valid)
  logic [7:0]  dq[$];
  logic        sq[$], rq[$];
  logic [63:0] d64;
  logic [15:0] sb, rb;

  task automatic pack_log();
    d64 = '0; sb = '0; rb = '0;
    for (int i = 0; i < dq.size() && i < 16; i++) begin
      if (i < 8) d64 = {d64[55:0], dq[i]};
      sb = {sb[14:0], sq[i]};
      rb = {rb[14:0], rq[i]};
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] x, input logic [7:0] s,
                      input int hold, output logic [7:0] c, output logic [7:0] f);
    int t;
    dq.delete(); sq.delete(); rq.delete();
    c = '0; f = '0;
    @(negedge clk);
    cmd_valid = 1; cmd_weights = w; cmd_inputs = x; cmd_steps = s;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin chk("accept_timeout", 0, 1); cmd_valid = 0; return; end
    @(posedge clk); #1;
    cmd_valid = 0;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 600) begin
      dq.push_back(nrn_data); sq.push_back(nrn_sel_w); rq.push_back(nrn_run);
      // junk offered while busy must be ignored
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_weights = $urandom; cmd_inputs = $urandom; cmd_steps = 8'($urandom);
      @(negedge clk); t++;
    end
    cmd_valid = 0;
    if (!rsp_valid) begin chk("rsp_timeout", 0, 1); return; end
    repeat (hold) @(negedge clk);
    c = rsp_count; f = rsp_first;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

`ifdef LIF_DRV_WEIGHT_CACHE_EN
  localparam int CACHED_LEN = 6, CACHED_SEL = 0;
`else
  localparam int CACHED_LEN = 10, CACHED_SEL = 4;
`endif

  initial begin
    logic [7:0]  c, f;
    logic [31:0] pw;
    int          t, nrun;
    bit          pulse;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_count", rsp_count, 8'h00);
    chk("rst_first", rsp_first, 8'hFF);
    chk("rst_data", nrn_data, 8'h00);
    chk("rst_run_sel", {nrn_run, nrn_sel_w}, 2'b00);
    #2 rst_n = 1;
    repeat (2) @(negedge clk);

    // byte order and load/run framing
    send(32'hFFFF_FFFF, 32'hA5A5_A5A5, 8'd3, 0, c, f);
    pack_log();
    chk("r29_cycles", dq.size(), 11);
    chk("r29_bytes", d64, 64'hFFFF_FFFF_A5A5_A5A5);
    chk("r29_sel_w", sb, 16'b000_1111_0000_000);
    chk("r29_run", rb, 16'b000_0000_0000_111);

    // neuron spikes every step; response held 20 cycles
    send(32'hFFFF_FFFF, 32'h0000_003F, 8'd4, 20, c, f);
    chk("r30_count", c, 8'd4);
    chk("r30_first", f, 8'd0);

    send(32'hFFFF_FFFF, 32'h0000_0000, 8'd10, 0, c, f);
    chk("r31_count", c, 8'd0);
    chk("r31_first", f, 8'hFF);

    // zero steps: straight to RESP after LOAD_X
    send(32'h1234_5678, 32'h9ABC_DEF0, 8'd0, 2, c, f);
    pack_log();
    chk("r32_cycles", dq.size(), 8);
    chk("r32_bytes", d64, 64'h1234_5678_9ABC_DEF0);
    chk("r32_run", rb, 16'h0000);
    chk("r32_count", c, 8'd0);
    chk("r32_first", f, 8'hFF);

    // identical commands: second one skips LOAD_W only with the cache
    send(32'hCAFE_F00D, 32'h0F0F_0F0F, 8'd2, 0, c, f);
    pack_log();
    chk("wc1_cycles", dq.size(), 10);
    chk("wc1_selw", $countones(sb), 4);
    send(32'hCAFE_F00D, 32'h0F0F_0F0F, 8'd2, 0, c, f);
    pack_log();
    chk("wc2_cycles", dq.size(), CACHED_LEN);
    chk("wc2_selw", $countones(sb), CACHED_SEL);

    // reset in the middle of RUN step 2
    @(negedge clk);
    cmd_valid = 1; cmd_weights = 32'hFFFF_FFFF; cmd_inputs = 32'h3F; cmd_steps = 8'd10;
    @(posedge clk); #1 cmd_valid = 0;
    nrun = 0; t = 0;
    while (nrun < 3 && t < 40) begin
      @(negedge clk); t++;
      if (nrn_run) nrun++;
    end
    chk("mid_run_reached", nrun, 3);
    #2 rst_n = 0;
    @(negedge clk);
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_count", rsp_count, 8'h00);
    chk("mrst_first", rsp_first, 8'hFF);
    chk("mrst_data", nrn_data, 8'h00);
    chk("mrst_run_sel", {nrn_run, nrn_sel_w}, 2'b00);
    #2 rst_n = 1;
    pulse = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid) pulse = 1; end
    chk("mrst_no_rsp", pulse, 0);

    // randomized traffic, some repeated weights
    pw = 32'hCAFE_F00D;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) pw = $urandom;
      send(pw, $urandom, 8'($urandom_range(0, 16)), $urandom_range(0, 4), c, f);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    send($urandom, 32'hFFFF_FFFF, 8'd255, 1, c, f);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
